// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampling UART receiver with 3-sample majority vote, optional parity and 1/2 stop bits
module uart_rx_gen2 #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);
   localparam int BW = ($clog2(DATA_WIDTH + 1) < 4) ? 4 : $clog2(DATA_WIDTH + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
   state_t                state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [PRESCALE_W-1:0] p_q, p_d, edge_q, edge_d, half, p_eff;
   logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
   logic [1:0]            smp_q, smp_d;
   logic                  par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
   logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, busy_q, busy_d;
   logic                  rx_s, vote, mid, last;

   assign rx_s  = sync_q[1];
   assign half  = p_q >> 1;
   assign mid   = edge_q == half;
   assign last  = edge_q == p_q - PRESCALE_W'(1);
   assign vote  = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
   assign p_eff = (Prescale < PRESCALE_W'(6)) ? PRESCALE_W'(6) : {Prescale[PRESCALE_W-1:1], 1'b0};

   // next-state logic: bit timing, voting, frame sequencing and registered output pulses
   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[0], RX_IN};
      p_d        = p_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      stop2_d    = stop2_q;
      edge_d     = last ? '0 : edge_q + PRESCALE_W'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      smp_d[1]   = (edge_q == half - PRESCALE_W'(2)) ? rx_s : smp_q[1];
      smp_d[0]   = (edge_q == half - PRESCALE_W'(1)) ? rx_s : smp_q[0];
      par_flag_d = par_flag_q;
      stp_flag_d = stp_flag_q;
      case (state_q)
         IDLE: begin
            edge_d = '0;
            bit_d  = '0;
            if (!rx_s) begin
               state_d   = START;
               p_d       = p_eff;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               stop2_d   = STOP2;
            end
         end
         START: begin
            if (mid && vote) begin
               state_d = IDLE;
               edge_d  = '0;
            end else if (last) state_d = DATA;
         end
         DATA: begin
            if (mid) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
            if (last) begin
               bit_d = bit_q + BW'(1);
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
                  bit_d   = '0;
               end
            end
         end
         PARITY: begin
            if (mid && (vote != (^shift_q ^ par_typ_q))) par_flag_d = 1'b1;
            if (last) state_d = STOP;
         end
         STOP: begin
            if (last) bit_d = bit_q + BW'(1);
            if (mid) begin
               if (!vote) stp_flag_d = 1'b1;
               if (bit_q == {{(BW-1){1'b0}}, stop2_q}) begin
                  state_d = DONE;
                  edge_d  = '0;
               end
            end
         end
         DONE: begin
            state_d    = IDLE;
            edge_d     = '0;
            bit_d      = '0;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      dv_d     = (state_d == DONE) && !par_flag_d && !stp_flag_d;
      pe_d     = (state_d == DONE) && par_flag_d;
      se_d     = (state_d == DONE) && stp_flag_d;
      p_data_d = dv_d ? shift_q : p_data_q;
      busy_d   = state_d != IDLE;
   end

   // state register; the synchroniser resets to the idle line level
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         p_q        <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         edge_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         smp_q      <= '0;
         par_flag_q <= 1'b0;
         stp_flag_q <= 1'b0;
         p_data_q   <= '0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         p_q        <= p_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         stop2_q    <= stop2_d;
         edge_q     <= edge_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         smp_q      <= smp_d;
         par_flag_q <= par_flag_d;
         stp_flag_q <= stp_flag_d;
         p_data_q   <= p_data_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
         busy_q     <= busy_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = dv_q;
   assign par_err    = pe_q;
   assign stp_err    = se_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: directed frames against an 8-bit and a 9-bit receiver sharing one line
module tb_uart_rx_gen2;
   logic       CLK, RST, RX, PAR_EN, PAR_TYP, STOP2;
   logic [5:0] PRESC;
   logic [7:0] pd8;
   logic       dv8, pe8, se8, busy8;
   logic [8:0] pd9;
   logic       dv9, pe9, se9, busy9;
   int         passed, total;
   int         dv8_n, pe8_n, se8_n, dv9_n, pe9_n, se9_n;
   logic [7:0] last8;
   logic [8:0] log9 [0:3];
   logic       dv8_prev, busy_after8;

   uart_rx_gen2 u8 (.CLK(CLK), .RST(RST), .RX_IN(RX), .Prescale(PRESC), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd8), .data_valid(dv8), .par_err(pe8),
      .stp_err(se8), .busy(busy8));
   uart_rx_gen2 #(.DATA_WIDTH(9), .PRESCALE_W(6)) u9 (.CLK(CLK), .RST(RST), .RX_IN(RX),
      .Prescale(PRESC), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd9),
      .data_valid(dv9), .par_err(pe9), .stp_err(se9), .busy(busy9));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // pulse monitor, sampled on the falling edge
   always @(negedge CLK) begin
      if (dv8_prev) busy_after8 = busy8;
      dv8_prev = dv8;
      if (dv8) begin
         last8 = pd8;
         dv8_n++;
      end
      if (pe8) pe8_n++;
      if (se8) se8_n++;
      if (dv9) begin
         if (dv9_n < 4) log9[dv9_n] = pd9;
         dv9_n++;
      end
      if (pe9) pe9_n++;
      if (se9) se9_n++;
   end

   task automatic clear();
      @(posedge CLK);
      dv8_n = 0; pe8_n = 0; se8_n = 0; dv9_n = 0; pe9_n = 0; se9_n = 0;
      busy_after8 = 1'b1;
      last8 = '0;
      for (int i = 0; i < 4; i++) log9[i] = '0;
   endtask

   task automatic idle(input int n);
      @(negedge CLK);
      RX = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // gl: line cycle forced low; ab: line cycle at which reset is pulsed and the frame abandoned
   task automatic send(input int w, input int p, input logic [8:0] d, input bit pen, input bit pb,
                       input bit s2, input bit st1, input bit st2, input int gl, input int ab);
      logic [15:0] fr;
      int n;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < w; i++) fr[1+i] = d[i];
      n = 1 + w;
      if (pen) begin
         fr[n] = pb;
         n++;
      end
      fr[n] = st1;
      n++;
      if (s2) begin
         fr[n] = st2;
         n++;
      end
      for (int i = 0; i < n * p; i++) begin
         @(negedge CLK);
         if (i == ab) begin
            RST = 1'b1;
            RX = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            return;
         end
         RX = (i == gl) ? 1'b0 : fr[i/p];
      end
   endtask

   task automatic cfg(input logic [5:0] p, input bit pen, input bit pt, input bit s2);
      @(negedge CLK);
      PRESC = p; PAR_EN = pen; PAR_TYP = pt; STOP2 = s2;
   endtask

   task automatic test_reset();
      RST = 1'b1; RX = 1'b1; PRESC = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      dv8_prev = 1'b0;
      repeat (3) @(negedge CLK);
      total++; if (pd8 !== 8'h00) $display("FAIL reset_pdata8: got %h want 00", pd8); else passed++;
      total++; if (dv8 !== 1'b0) $display("FAIL reset_dv8: got %b want 0", dv8); else passed++;
      total++; if (pe8 !== 1'b0) $display("FAIL reset_pe8: got %b want 0", pe8); else passed++;
      total++; if (se8 !== 1'b0) $display("FAIL reset_se8: got %b want 0", se8); else passed++;
      total++; if (busy8 !== 1'b0) $display("FAIL reset_busy8: got %b want 0", busy8); else passed++;
      total++; if (pd9 !== 9'h000) $display("FAIL reset_pdata9: got %h want 000", pd9); else passed++;
      total++; if (busy9 !== 1'b0) $display("FAIL reset_busy9: got %b want 0", busy9); else passed++;
      RST = 1'b0;
      idle(4);
   endtask

   task automatic test_clean();
      cfg(6'd8, 1'b0, 1'b0, 1'b0);
      clear();
      send(8, 8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL clean_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'hA5) $display("FAIL clean_data: got %h want a5", last8); else passed++;
      total++; if (pe8_n !== 0) $display("FAIL clean_pe: got %0d want 0", pe8_n); else passed++;
      total++; if (se8_n !== 0) $display("FAIL clean_se: got %0d want 0", se8_n); else passed++;
      total++; if (busy_after8 !== 1'b0) $display("FAIL clean_busy_after: got %b want 0", busy_after8); else passed++;
   endtask

   task automatic test_parity();
      cfg(6'd8, 1'b1, 1'b0, 1'b0);
      clear();
      send(8, 8, 9'h00F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (pe8_n !== 1) $display("FAIL par_bad_pe: got %0d want 1", pe8_n); else passed++;
      total++; if (dv8_n !== 0) $display("FAIL par_bad_dv: got %0d want 0", dv8_n); else passed++;
      total++; if (se8_n !== 0) $display("FAIL par_bad_se: got %0d want 0", se8_n); else passed++;
      total++; if (pd8 !== 8'hA5) $display("FAIL par_bad_hold: got %h want a5", pd8); else passed++;
      clear();
      send(8, 8, 9'h00F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL par_ok_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'h0F) $display("FAIL par_ok_data: got %h want 0f", last8); else passed++;
      total++; if (pe8_n !== 0) $display("FAIL par_ok_pe: got %0d want 0", pe8_n); else passed++;
   endtask

   task automatic test_stop2();
      cfg(6'd8, 1'b0, 1'b0, 1'b1);
      clear();
      send(8, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
      idle(40);
      total++; if (se8_n !== 1) $display("FAIL stop_bad_se: got %0d want 1", se8_n); else passed++;
      total++; if (pe8_n !== 0) $display("FAIL stop_bad_pe: got %0d want 0", pe8_n); else passed++;
      total++; if (dv8_n !== 0) $display("FAIL stop_bad_dv: got %0d want 0", dv8_n); else passed++;
      total++; if (pd8 !== 8'h0F) $display("FAIL stop_bad_hold: got %h want 0f", pd8); else passed++;
      clear();
      send(8, 8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL stop_ok_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'h3C) $display("FAIL stop_ok_data: got %h want 3c", last8); else passed++;
      total++; if (se8_n !== 0) $display("FAIL stop_ok_se: got %0d want 0", se8_n); else passed++;
   endtask

   task automatic test_glitch();
      bit seen, done;
      cfg(6'd16, 1'b0, 1'b0, 1'b0);
      clear();
      seen = 1'b0;
      done = 1'b0;
      @(negedge CLK);
      RX = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RX = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (busy8) seen = 1'b1;
         else if (seen) begin
            done = 1'b1;
            break;
         end
      end
      total++; if (seen !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", seen); else passed++;
      total++; if (done !== 1'b1) $display("FAIL glitch_busy_fall: got %b want 1", done); else passed++;
      idle(30);
      total++; if (dv8_n !== 0) $display("FAIL glitch_dv: got %0d want 0", dv8_n); else passed++;
      total++; if (pe8_n !== 0) $display("FAIL glitch_pe: got %0d want 0", pe8_n); else passed++;
      total++; if (se8_n !== 0) $display("FAIL glitch_se: got %0d want 0", se8_n); else passed++;
   endtask

   task automatic test_majority();
      cfg(6'd8, 1'b0, 1'b0, 1'b0);
      clear();
      send(8, 8, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 36, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL vote_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'hFF) $display("FAIL vote_data: got %h want ff", last8); else passed++;
   endtask

   task automatic test_back_to_back();
      cfg(6'd32, 1'b1, 1'b1, 1'b0);
      clear();
      send(9, 32, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      send(9, 32, 9'h1A5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(100);
      total++; if (dv9_n !== 2) $display("FAIL b2b_dv: got %0d want 2", dv9_n); else passed++;
      total++; if (log9[0] !== 9'h1A5) $display("FAIL b2b_data0: got %h want 1a5", log9[0]); else passed++;
      total++; if (log9[1] !== 9'h1A5) $display("FAIL b2b_data1: got %h want 1a5", log9[1]); else passed++;
      total++; if (pe9_n !== 0) $display("FAIL b2b_pe: got %0d want 0", pe9_n); else passed++;
      total++; if (se9_n !== 0) $display("FAIL b2b_se: got %0d want 0", se9_n); else passed++;
   endtask

   task automatic test_reset_mid();
      cfg(6'd8, 1'b0, 1'b0, 1'b0);
      clear();
      send(8, 8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 44);
      total++; if (pd8 !== 8'h00) $display("FAIL mid_pdata: got %h want 00", pd8); else passed++;
      total++; if (dv8 !== 1'b0) $display("FAIL mid_dv: got %b want 0", dv8); else passed++;
      total++; if (pe8 !== 1'b0) $display("FAIL mid_pe: got %b want 0", pe8); else passed++;
      total++; if (se8 !== 1'b0) $display("FAIL mid_se: got %b want 0", se8); else passed++;
      total++; if (busy8 !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy8); else passed++;
      idle(40);
      total++; if (dv8_n + pe8_n + se8_n !== 0) $display("FAIL mid_no_pulse: got %0d want 0", dv8_n + pe8_n + se8_n); else passed++;
      clear();
      send(8, 8, 9'h055, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL mid_next_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'h55) $display("FAIL mid_next_data: got %h want 55", last8); else passed++;
   endtask

   task automatic test_clamp();
      cfg(6'd3, 1'b0, 1'b0, 1'b0);
      clear();
      send(8, 6, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL clamp_low_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'h5A) $display("FAIL clamp_low_data: got %h want 5a", last8); else passed++;
      cfg(6'd9, 1'b0, 1'b0, 1'b0);
      clear();
      send(8, 8, 9'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(40);
      total++; if (dv8_n !== 1) $display("FAIL clamp_odd_dv: got %0d want 1", dv8_n); else passed++;
      total++; if (last8 !== 8'hC3) $display("FAIL clamp_odd_data: got %h want c3", last8); else passed++;
   endtask

   initial begin
      passed = 0;
      total = 0;
      dv8_n = 0; pe8_n = 0; se8_n = 0; dv9_n = 0; pe9_n = 0; se9_n = 0;
      busy_after8 = 1'b1;
      last8 = '0;
      test_reset();
      test_clean();
      test_parity();
      test_stop2();
      test_glitch();
      test_majority();
      test_back_to_back();
      test_reset_mid();
      test_clamp();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/uart_rx_gen2.md
Name: uart_rx_gen2

Overview:
Parametrised second-generation UART receiver, drop-in successor to the current 8-bit RX in the UART subsystem.
- Generalised data width and prescale width.
- New: run-time 1/2 stop bits, 3-sample majority voting, RX_IN synchroniser, separate per-frame error flags, busy flag.
- Deserialised word goes to the system data-sync stage.

Parameters:
DATA_WIDTH, 8, frame data bits (legal 5..9), LSB first on the line.
PRESCALE_W, 6, width of Prescale input.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous reset, active-high.
RX_IN  in  1  asynchronous serial line, idle high.
Prescale  in  PRESCALE_W  oversampling ratio (clocks per bit); even, >=6.
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
STOP2  in  1  1 = two stop bits, 0 = one.
P_DATA  out  DATA_WIDTH  received word, held until next valid frame.
data_valid  out  1  one-cycle pulse, frame good.
par_err  out  1  one-cycle pulse, parity mismatch.
stp_err  out  1  one-cycle pulse, any stop bit sampled 0.
busy  out  1  high while not in IDLE.

Behaviour:
- Reset state (RST high at a CLK edge): all outputs 0, FSM in IDLE, counters 0, synchroniser flops set to 1.
- Synchroniser: RX_IN passes through 2 flops; rx_s is the second flop. All logic uses rx_s, so pin-to-logic latency is 2 cycles.
- Config latch: Prescale, PAR_EN, PAR_TYP, STOP2 are captured on IDLE->START. Changes mid-frame have no effect.
- Prescale clamp: values below 6 are treated as 6. Odd values are rounded down (LSB ignored).
- edge_cnt: counts 0..P-1 per bit, where P is the latched prescale. It wraps to 0 at P-1 and bit_cnt increments on the wrap.
- Sampling: rx_s is sampled at edge_cnt = P/2-2, P/2-1 and P/2. The bit value is the majority of the 3 samples, registered at edge_cnt = P/2.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: rx_s==0 -> START, edge_cnt=0.
  - START: at edge_cnt=P/2, if voted bit==1 (glitch) -> IDLE with no output pulse. Otherwise at edge_cnt=P-1 -> DATA.
  - DATA: shift the voted bit into the shift register at position bit index (LSB first). After bit DATA_WIDTH-1 completes (edge_cnt=P-1) -> PARITY if PAR_EN, else STOP.
  - PARITY: compare the voted bit with the expected parity, computed as XOR of the data bits, inverted when PAR_TYP=1. A mismatch sets the internal par_flag. At edge_cnt=P-1 -> STOP.
  - STOP: a voted 0 in any stop bit sets the internal stp_flag. After 1 stop bit (STOP2=0) or 2 (STOP2=1), at edge_cnt=P/2 of the last stop bit -> DONE. Exit happens mid-bit so back-to-back frames are not missed.
  - DONE: lasts one cycle, then -> IDLE.
    - If no flags are set: P_DATA <= shift register and data_valid=1.
    - Otherwise par_err/stp_err pulse per flag, data_valid stays 0 and P_DATA is unchanged.
    - Flags clear on leaving DONE.
- Output timing: all outputs are registered, and pulses are exactly 1 cycle wide.
- Back-to-back frames: IDLE accepts a new start edge in the cycle directly after DONE.
- Line held low after a stop error (break): the FSM re-enters START, then goes through the normal flow. No extra break output.
- busy: 0 only in IDLE.
- Reset mid-frame: at the RST edge, everything returns to the reset state. No pulse is emitted for the aborted frame.
- Width: edge_cnt is PRESCALE_W bits. bit_cnt is ceil(log2(DATA_WIDTH+1)) bits, minimum 4.

Test Plan:
- Clean frame: DATA_WIDTH=8, Prescale=8, PAR_EN=0, STOP2=0, send 0xA5 -> one data_valid pulse with P_DATA=0xA5, par_err=stp_err=0, busy low 1 cycle after the pulse.
- Parity: PAR_EN=1, PAR_TYP=0, send 0x0F with parity bit 1 -> par_err pulse, no data_valid, P_DATA keeps its previous value. Same data with parity 0 -> data_valid, P_DATA=0x0F.
- Two stop bits and error: STOP2=1, send 0x3C with second stop bit 0 -> stp_err pulse only. Repeat with both stop bits 1 -> data_valid with P_DATA=0x3C.
- Glitch and majority voting:
  - Drive RX_IN low for 2 cycles at Prescale=16 -> no pulse, busy returns to 0 within 10 cycles.
  - Inside a data bit of 1, inject a single-cycle 0 at sample point P/2-1 -> the bit still reads 1.
- Parametrisation: DATA_WIDTH=9, Prescale=32, odd parity, send 0x1A5 back-to-back twice with no idle gap -> two data_valid pulses, each with P_DATA=0x1A5.
- Reset mid-frame: assert RST during DATA bit 4 -> next cycle all outputs 0, FSM IDLE. A following clean frame 0x55 is received correctly.
